// File: rtl/pkg_sfrs_definition.sv
// Shared SFR-side types for the PWM dead-time generator: config bundle and FSM state encoding.
package pkg_sfrs_definition;

    localparam int unsigned PwmDtWidth = 8;

    typedef struct packed {
        logic                  en;
        logic                  pol_h;
        logic                  pol_l;
        logic [PwmDtWidth-1:0] dt_rise;
        logic [PwmDtWidth-1:0] dt_fall;
        logic                  fault_f;
    } pwm_dt_cfg_t;

    typedef enum logic [2:0] {
        StOff    = 3'd0,
        StLow    = 3'd1,
        StDtRise = 3'd2,
        StHigh   = 3'd3,
        StDtFall = 3'd4,
        StFault  = 3'd5
    } pwm_dt_state_t;

endpackage

// File: rtl/pwm_dt_sync.sv
// Two-flop synchroniser bringing the asynchronous fault request into the PWM clock domain.
module pwm_dt_sync (
    input  logic pwm_clk,
    input  logic sys_rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge pwm_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary high/low gate driver with programmable both-off intervals around every PWM edge.
// Optional latched fault shutdown is built when PWM_DT_FAULT_EN is defined.
module pwm_deadtime_gen
    import pkg_sfrs_definition::*;
#(
    parameter int unsigned DtWidth = PwmDtWidth
) (
    input  logic               pwm_clk,
    input  logic               sys_rst_n,
    input  logic               pwm_in_i,
    input  logic               dt_en_i,
    input  logic [DtWidth-1:0] dt_rise_i,
    input  logic [DtWidth-1:0] dt_fall_i,
    input  logic               pol_h_i,
    input  logic               pol_l_i,
    input  logic               fault_in_i,
    input  logic               fault_clr_i,
    output logic               out_h_o,
    output logic               out_l_o,
    output logic               dt_active_o,
    output logic               fault_flag_o
);

    pwm_dt_state_t      state_q, state_d;
    logic [DtWidth-1:0] cnt_q, cnt_d;
    logic               pwm_in_q;
    logic               fault_flag_q, fault_flag_d;
    logic               fault_s;
    logic               fault_clr_s;
    pwm_dt_cfg_t        cfg;

    assign cfg.en      = dt_en_i;
    assign cfg.pol_h   = pol_h_i;
    assign cfg.pol_l   = pol_l_i;
    assign cfg.dt_rise = PwmDtWidth'(dt_rise_i);
    assign cfg.dt_fall = PwmDtWidth'(dt_fall_i);
    assign cfg.fault_f = fault_flag_q;

`ifdef PWM_DT_FAULT_EN
    pwm_dt_sync u_fault_sync (
        .pwm_clk   (pwm_clk),
        .sys_rst_n (sys_rst_n),
        .d_i       (fault_in_i),
        .q_o       (fault_s)
    );
    assign fault_clr_s = fault_clr_i;
`else
    logic unused_fault;
    assign unused_fault = fault_in_i ^ fault_clr_i;
    assign fault_s      = 1'b0;
    assign fault_clr_s  = 1'b0;
`endif

    always_ff @(posedge pwm_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= StOff;
            cnt_q        <= '0;
            pwm_in_q     <= 1'b0;
            fault_flag_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pwm_in_q     <= pwm_in_i;
            fault_flag_q <= fault_flag_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fault_flag_d = fault_flag_q;

        if (fault_s) begin
            state_d      = StFault;
            cnt_d        = '0;
            fault_flag_d = 1'b1;
        end else if (state_q == StFault) begin
            // Only reached once the synchronised fault has dropped.
            if (fault_clr_s) begin
                state_d      = StOff;
                fault_flag_d = 1'b0;
            end
        end else if (!cfg.en) begin
            state_d = StOff;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StOff: begin
                    state_d = pwm_in_q ? StHigh : StLow;
                end
                StLow: begin
                    if (pwm_in_q) begin
                        if (cfg.dt_rise == '0) begin
                            state_d = StHigh;
                        end else begin
                            state_d = StDtRise;
                            cnt_d   = DtWidth'(cfg.dt_rise - PwmDtWidth'(1));
                        end
                    end
                end
                StDtRise: begin
                    if (!pwm_in_q) begin
                        state_d = StLow;
                    end else if (cnt_q == '0) begin
                        state_d = StHigh;
                    end else begin
                        cnt_d = cnt_q - DtWidth'(1);
                    end
                end
                StHigh: begin
                    if (!pwm_in_q) begin
                        if (cfg.dt_fall == '0) begin
                            state_d = StLow;
                        end else begin
                            state_d = StDtFall;
                            cnt_d   = DtWidth'(cfg.dt_fall - PwmDtWidth'(1));
                        end
                    end
                end
                StDtFall: begin
                    if (pwm_in_q) begin
                        state_d = StHigh;
                    end else if (cnt_q == '0) begin
                        state_d = StLow;
                    end else begin
                        cnt_d = cnt_q - DtWidth'(1);
                    end
                end
                default: begin
                    state_d = StOff;
                end
            endcase
        end
    end

    // Gate enables come straight from the state register, so h/l can never overlap.
    logic h_on, l_on;
    assign h_on         = (state_q == StHigh);
    assign l_on         = (state_q == StLow);
    assign dt_active_o  = (state_q == StDtRise) || (state_q == StDtFall);
    assign out_h_o      = h_on ^ cfg.pol_h;
    assign out_l_o      = l_on ^ cfg.pol_l;
    assign fault_flag_o = cfg.fault_f;

endmodule
